mcu_control_unit: RTL and testbench
===================================

# mcu_control_unit

Instruction sequencer for the 8-bit microcontroller. It drives the ALU's operand, mode and enable inputs and consumes the ALU's `Out`, `CFlags` and `Flags` results. It fetches 16-bit instructions from a synchronous program ROM, decodes them, executes them through the ALU, and writes results back to an accumulator and a status register. It sits between program memory and the ALU and is the initiator side of the ALU port set.

## Interface
- Clocking and reset: one clock; reset is synchronous and active-low.

Parameters:
- `PC_W`, default 8: program counter and ROM address width; the PC wraps modulo 2^PC_W.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `start` in 1: begin execution; sampled in IDLE or HALT only.
- `prog_addr` out PC_W: ROM read address.
- `prog_data` in 16: ROM data, valid one cycle after `prog_addr`.
- `Operand1` out 8: ALU operand A (the accumulator).
- `Operand2` out 8: ALU operand B (register B or the immediate).
- `Mode` out 4: ALU mode.
- `E` out 1: ALU enable.
- `Out` in 8: ALU result; combinational, valid in the same cycle.
- `CFlags` in 4: ALU condition flags.
- `Flags` in 1: ALU single flag.
- `acc` out 8: accumulator.
- `sr` out 4: status register, holds the last captured `CFlags`.
- `flag` out 1: last captured `Flags`.
- `busy` out 1: high in FETCH, DECODE and EXEC.
- `halted` out 1: high in HALT.
- `illegal` out 1: sticky illegal-opcode indicator.

## Operation
- Instruction format: [15:12] opcode, [11:8] mode field M, [7:0] immediate I.
- Opcodes:
  - 0x0 NOP: no effect.
  - 0x1 LDA: `acc`←I.
  - 0x2 LDB: B←I.
  - 0x3 ALU: `acc`←Out(acc, B, M); `sr`←CFlags; `flag`←Flags.
  - 0x4 ALUI: same as ALU, with I as operand B.
  - 0x5 JMP: PC←I[PC_W-1:0].
  - 0x6 JC: if `sr[M[1:0]]`==1, PC←I; otherwise no effect.
  - 0xF HALT: go to HALT.
  - All others: illegal (see Configuration).
- FSM states: IDLE, FETCH, DECODE, EXEC, HALT.
  - IDLE: `start`=1 → FETCH.
  - FETCH: `prog_addr`=PC; PC←PC+1 (wraps); → DECODE.
  - DECODE: IR←`prog_data`; → EXEC.
  - EXEC: perform the operation. HALT opcode → HALT; otherwise → FETCH.
  - HALT: `start`=1 → PC←0, → FETCH. Otherwise stay in HALT.
- A jump in EXEC overrides the PC increment made in FETCH.
- `E`=1 only in EXEC of ALU and ALUI instructions.
- Whenever `E`=0, `Operand1`, `Operand2` and `Mode` are driven 0.
- `acc`, `sr` and `flag` are written only by the opcodes listed above. Non-ALU opcodes leave `sr` and `flag` unchanged.
- `start` is ignored while `busy`=1.
- Register B is internal and resets to 0.

## Timing
- Every instruction takes exactly 3 cycles (FETCH, DECODE, EXEC).
- If `start` is sampled high at edge k, FETCH occupies cycle k+1 and the first EXEC result is visible after edge k+3.
- The ALU is treated as combinational. `Out`, `CFlags` and `Flags` are captured on the edge that ends EXEC.
- Reset value of every output is 0: `prog_addr`, operands, `Mode`, `E`, `acc`, `sr`, `flag`, `busy`, `halted`, `illegal`. PC=0, B=0, IR=0, state IDLE.
- Reset has priority over every other event. Reset asserted during any state, including EXEC, returns all state to reset values on that edge; no writeback occurs.
- PC=2^PC_W−1 followed by FETCH gives the next `prog_addr`=0.
- JMP or JC to the instruction's own address loops indefinitely; this is legal.

## Configuration
- `CU_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in EXEC sets `illegal`=1 (sticky until reset) and the FSM goes to HALT.
  - `start` from HALT does not clear `illegal`.
- `CU_ILLEGAL_TRAP_EN` undefined:
  - Illegal opcodes execute as NOP.
  - `illegal` is tied to 0.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles during activity → all outputs 0, `busy`=0, and the next `start` fetches address 0.
- Program LDA 12; LDB 5; ALU M=0000; HALT, with a bench ALU model in which mode 0 adds, and `start` at edge k:
  - `E` is high only in cycle k+9.
  - `acc`=17 after edge k+9.
  - `halted`=1 after edge k+12.
- JMP 0xFF, then NOP at 0xFF → the following `prog_addr` is 0x00 (wrap).
- JC branch condition, with a bench ALU that sets CFlags=0100 for ALUI:
  - ALUI followed by JC M=10 I=0x20 → next fetch at 0x20.
  - JC M=00 with the same flags → falls through to PC+1.
- Opcode 0x7 at address 3:
  - With `CU_ILLEGAL_TRAP_EN` → `illegal`=1 and `halted`=1.
  - Without the macro → execution continues at address 4 and `illegal`=0.
- `rst_n`=0 during EXEC of ALU → `acc` stays 0 and `E`=0 on the next cycle.

Source files
------------

// File: rtl/mcu_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : mcu_control_unit
// Brief    : FETCH/DECODE/EXEC sequencer that drives the ALU port set and owns
//            the accumulator and status register. Optional macro:
//            CU_ILLEGAL_TRAP_EN (illegal opcodes trap to HALT, sticky flag).
// Revision : 1.0
// ============================================================================
module mcu_control_unit #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] prog_addr,
    input  logic [15:0]     prog_data,
    output logic [7:0]      Operand1,
    output logic [7:0]      Operand2,
    output logic [3:0]      Mode,
    output logic            E,
    input  logic [7:0]      Out,
    input  logic [3:0]      CFlags,
    input  logic            Flags,
    output logic [7:0]      acc,
    output logic [3:0]      sr,
    output logic            flag,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    localparam logic [3:0] C_OP_NOP  = 4'h0;
    localparam logic [3:0] C_OP_LDA  = 4'h1;
    localparam logic [3:0] C_OP_LDB  = 4'h2;
    localparam logic [3:0] C_OP_ALU  = 4'h3;
    localparam logic [3:0] C_OP_ALUI = 4'h4;
    localparam logic [3:0] C_OP_JMP  = 4'h5;
    localparam logic [3:0] C_OP_JC   = 4'h6;
    localparam logic [3:0] C_OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_b;
    // Instruction register keeps only the fields EXEC consumes.
    logic [3:0]      r_op;
    logic [1:0]      r_sel;
    logic [7:0]      r_imm;

    logic [3:0]      w_dec_op;
    logic            w_dec_alu;
    logic            w_jump;
    logic            w_trap;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_next_pc;

    assign w_dec_op  = prog_data[15:12];
    assign w_dec_alu = (w_dec_op == C_OP_ALU) || (w_dec_op == C_OP_ALUI);
    assign w_target  = PC_W'(r_imm);
    assign w_jump    = (r_op == C_OP_JMP) || ((r_op == C_OP_JC) && sr[r_sel]);
    // A taken jump replaces the increment already applied during FETCH.
    assign w_next_pc = w_jump ? w_target : r_pc;

`ifdef CU_ILLEGAL_TRAP_EN
    always_comb begin
        w_trap = 1'b1;
        case (r_op)
            C_OP_NOP, C_OP_LDA, C_OP_LDB, C_OP_ALU, C_OP_ALUI,
            C_OP_JMP, C_OP_JC, C_OP_HALT: w_trap = 1'b0;
            default:                      w_trap = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else if ((r_state == S_EXEC) && w_trap) begin
            illegal <= 1'b1;
        end
    end
`else
    assign w_trap  = 1'b0;
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_b       <= 8'h00;
            r_op      <= 4'h0;
            r_sel     <= 2'b00;
            r_imm     <= 8'h00;
            prog_addr <= '0;
            Operand1  <= 8'h00;
            Operand2  <= 8'h00;
            Mode      <= 4'h0;
            E         <= 1'b0;
            acc       <= 8'h00;
            sr        <= 4'h0;
            flag      <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        prog_addr <= r_pc;
                        busy      <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_pc    <= r_pc + PC_W'(1);
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_op  <= w_dec_op;
                    r_sel <= prog_data[9:8];
                    r_imm <= prog_data[7:0];
                    E     <= w_dec_alu;
                    if (w_dec_alu) begin
                        Operand1 <= acc;
                        Operand2 <= (w_dec_op == C_OP_ALUI) ? prog_data[7:0] : r_b;
                        Mode     <= prog_data[11:8];
                    end
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    E        <= 1'b0;
                    Operand1 <= 8'h00;
                    Operand2 <= 8'h00;
                    Mode     <= 4'h0;
                    case (r_op)
                        C_OP_LDA: acc <= r_imm;
                        C_OP_LDB: r_b <= r_imm;
                        C_OP_ALU, C_OP_ALUI: begin
                            acc  <= Out;
                            sr   <= CFlags;
                            flag <= Flags;
                        end
                        default: ;
                    endcase
                    if ((r_op == C_OP_HALT) || w_trap) begin
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_pc      <= w_next_pc;
                        prog_addr <= w_next_pc;
                        r_state   <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        r_pc      <= '0;
                        prog_addr <= '0;
                        busy      <= 1'b1;
                        halted    <= 1'b0;
                        r_state   <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mcu_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcu_control_unit
// Brief    : Directed self-checking bench for mcu_control_unit with a small
//            ROM and ALU model. Honours CU_ILLEGAL_TRAP_EN.
// Revision : 1.0
// ============================================================================
module tb_mcu_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data = 16'h0000;
    logic [7:0]  Operand1, Operand2;
    logic [3:0]  Mode;
    logic        E;
    logic [7:0]  Out;
    logic [3:0]  CFlags;
    logic        Flags;
    logic [7:0]  acc;
    logic [3:0]  sr;
    logic        flag, busy, halted, illegal;

    logic [15:0] rom [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) prog_data <= rom[prog_addr];

    // ALU model: mode 0 adds, other modes xor; mode 1 reports CFlags=0100.
    always_comb begin
        Out    = (Mode == 4'h0) ? Operand1 + Operand2 : Operand1 ^ Operand2;
        CFlags = (Mode == 4'h1) ? 4'b0100 : 4'b1001;
        Flags  = Out[4];
    end

    mcu_control_unit #(.PC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .Operand1(Operand1), .Operand2(Operand2), .Mode(Mode), .E(E),
        .Out(Out), .CFlags(CFlags), .Flags(Flags),
        .acc(acc), .sr(sr), .flag(flag),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_prog_addr"}, 16'(prog_addr), 16'h0);
        check({pfx, "_op1"},       16'(Operand1),  16'h0);
        check({pfx, "_op2"},       16'(Operand2),  16'h0);
        check({pfx, "_mode"},      16'(Mode),      16'h0);
        check({pfx, "_E"},         16'(E),         16'h0);
        check({pfx, "_acc"},       16'(acc),       16'h0);
        check({pfx, "_sr"},        16'(sr),        16'h0);
        check({pfx, "_flag"},      16'(flag),      16'h0);
        check({pfx, "_busy"},      16'(busy),      16'h0);
        check({pfx, "_halted"},    16'(halted),    16'h0);
        check({pfx, "_illegal"},   16'(illegal),   16'h0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;

        // Power-up reset
        do_reset();
        check_zero("rst0");

        // Program A: LDA 12; LDB 5; ALU add; HALT
        rom[0] = 16'h100C;
        rom[1] = 16'h2005;
        rom[2] = 16'h3000;
        rom[3] = 16'hF000;
        pulse_start();
        check("a_busy", 16'(busy), 16'h1);
        check("a_addr0", 16'(prog_addr), 16'h00);
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("a_E", 16'(E), (i == 8) ? 16'h1 : 16'h0);
            if (i == 8) begin
                check("a_op1", 16'(Operand1), 16'h0C);
                check("a_op2", 16'(Operand2), 16'h05);
                check("a_mode", 16'(Mode), 16'h0);
            end
            if (i == 9) begin
                check("a_acc", 16'(acc), 16'h11);
                check("a_sr", 16'(sr), 16'h9);
                check("a_flag", 16'(flag), 16'h1);
                check("a_op1_idle", 16'(Operand1), 16'h00);
            end
            if (i == 11) check("a_not_halted", 16'(halted), 16'h0);
        end
        check("a_halted", 16'(halted), 16'h1);
        check("a_busy_end", 16'(busy), 16'h0);

        // Program B: JMP 0xFF, NOP at 0xFF, wrap to 0x00
        rom[0]    = 16'h50FF;
        rom[8'hFF] = 16'h0000;
        pulse_start();
        check("b_unhalt", 16'(halted), 16'h0);
        check("b_addr0", 16'(prog_addr), 16'h00);
        repeat (3) tick();
        check("b_jmp", 16'(prog_addr), 16'hFF);
        repeat (3) tick();
        check("b_wrap", 16'(prog_addr), 16'h00);
        check("b_acc_kept", 16'(acc), 16'h11);

        // Reset while running
        tick();
        do_reset();
        check_zero("rst1");

        // Program C: ALUI M=1 then JC taken / JC not taken
        rom[0]     = 16'h4133;
        rom[1]     = 16'h6220;
        rom[8'h20] = 16'h6040;
        rom[8'h21] = 16'hF000;
        pulse_start();
        check("c_addr0", 16'(prog_addr), 16'h00);
        repeat (2) tick();
        check("c_E", 16'(E), 16'h1);
        check("c_op1", 16'(Operand1), 16'h00);
        check("c_op2", 16'(Operand2), 16'h33);
        check("c_mode", 16'(Mode), 16'h1);
        tick();
        check("c_acc", 16'(acc), 16'h33);
        check("c_sr", 16'(sr), 16'h4);
        check("c_flag", 16'(flag), 16'h1);
        check("c_E_off", 16'(E), 16'h0);
        check("c_op2_off", 16'(Operand2), 16'h00);
        repeat (3) tick();
        check("c_jc_taken", 16'(prog_addr), 16'h20);
        repeat (3) tick();
        check("c_jc_fall", 16'(prog_addr), 16'h21);
        check("c_sr_kept", 16'(sr), 16'h4);
        repeat (3) tick();
        check("c_halted", 16'(halted), 16'h1);

        // Program D: illegal opcode 0x7 at address 3
        rom[0] = 16'h0000;
        rom[1] = 16'h0000;
        rom[2] = 16'h0000;
        rom[3] = 16'h7000;
        rom[4] = 16'h105A;
        rom[5] = 16'hF000;
        pulse_start();
        repeat (12) tick();
`ifdef CU_ILLEGAL_TRAP_EN
        check("d_illegal", 16'(illegal), 16'h1);
        check("d_halted", 16'(halted), 16'h1);
        check("d_acc_kept", 16'(acc), 16'h33);
        pulse_start();
        tick();
        check("d_restart_busy", 16'(busy), 16'h1);
        check("d_sticky", 16'(illegal), 16'h1);
`else
        check("d_illegal", 16'(illegal), 16'h0);
        check("d_halted", 16'(halted), 16'h0);
        check("d_next", 16'(prog_addr), 16'h04);
        repeat (3) tick();
        check("d_acc", 16'(acc), 16'h5A);
        repeat (3) tick();
        check("d_halt_end", 16'(halted), 16'h1);
        check("d_illegal_end", 16'(illegal), 16'h0);
`endif

        // Program E: reset during EXEC of an ALU op
        do_reset();
        check("e_rst_illegal", 16'(illegal), 16'h0);
        rom[0] = 16'h4022;
        pulse_start();
        repeat (2) tick();
        check("e_in_exec", 16'(E), 16'h1);
        rst_n = 1'b0;
        tick();
        check("e_acc", 16'(acc), 16'h00);
        check("e_E", 16'(E), 16'h0);
        check("e_sr", 16'(sr), 16'h0);
        check("e_busy", 16'(busy), 16'h0);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
